// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a single-port 512x16 RAM into a FIFO with a one-entry
// registered output stage. Producer pushes over in_valid/in_ready, consumer pops
// over out_valid/out_ready; one RAM operation (read or write) per cycle.
//
// Optional feature macro: RAM_FIFO_BYPASS_EN
//   When defined, a push into an empty FIFO whose output slot is free loads
//   out_data directly without touching the RAM (push-to-out_valid in 1 edge).
//   When undefined, every word is written to RAM and then fetched (2 edges).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of pointers, occupancy and out_valid
//   in_data/in_valid/in_ready      push stream
//   out_data/out_valid/out_ready   pop stream (out_data/out_valid registered)
//   level             words held = RAM occupancy + output register
//   ram_in/ram_add/ram_read/ram_write/ram_en/ram_out   RAM512_16bit port
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_count_q, mem_count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic slot_free;
  logic pop;

  // Output slot can accept a new word this cycle (empty or being consumed).
  assign slot_free = !out_valid_q || out_ready;
  assign pop       = out_valid_q && out_ready;

  // Single-port arbitration: flush, then fetch into the output slot, then write.
  always_comb begin
    in_ready    = 1'b0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_add     = wr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (!rst_n) begin
      // RAM is kept idle while reset is asserted; state is held in reset.
    end else if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      out_valid_d = 1'b0;
    end else if (slot_free && (mem_count_q != '0)) begin
      ram_read    = 1'b1;
      ram_add     = rd_ptr_q;
      out_data_d  = ram_out;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      mem_count_d = mem_count_q - CNT_W'(1);
    end else begin
      if (pop) begin
        out_valid_d = 1'b0;
      end
`ifdef RAM_FIFO_BYPASS_EN
      // Empty RAM and free slot: skip the RAM round trip entirely.
      if ((mem_count_q == '0) && slot_free) begin
        in_ready = 1'b1;
        if (in_valid) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
        end
      end else if (mem_count_q < DEPTH_C) begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_write   = 1'b1;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          mem_count_d = mem_count_q + CNT_W'(1);
        end
      end
`else
      if (mem_count_q < DEPTH_C) begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_write   = 1'b1;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          mem_count_d = mem_count_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ram_en    = ram_read || ram_write;
  assign ram_in    = in_data;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = mem_count_q + CNT_W'(out_valid_q);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: drives ram_fifo_ctrl against a behavioural 512x16 RAM.
// A negedge monitor keeps a scoreboard of accepted words, checks popped data,
// level and RAM addresses; directed sequences cover reset, fill, wrap,
// fetch-vs-push priority, flush and latency.
module tb_ram_fifo_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   level;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_add;
  logic          ram_read;
  logic          ram_write;
  logic          ram_en;
  logic [DW-1:0] ram_out;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .ram_in   (ram_in),
    .ram_add  (ram_add),
    .ram_read (ram_read),
    .ram_write(ram_write),
    .ram_en   (ram_en),
    .ram_out  (ram_out)
  );

  // Behavioural single-port RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en && ram_write) mem[ram_add] <= ram_in;
  end
  assign ram_out = ram_read ? mem[ram_add] : '0;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [DW-1:0] sb [$];
  logic [AW-1:0] wr_m = '0;
  logic [AW-1:0] rd_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle where inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      wr_m = '0;
      rd_m = '0;
    end else begin
      check("mon_level", 32'(level), 32'(sb.size()));
      check("mon_ram_en", 32'(ram_en), 32'(ram_read | ram_write));
      if (ram_write) begin
        check("mon_wr_add", 32'(ram_add), 32'(wr_m));
        wr_m = wr_m + 9'd1;
      end
      if (ram_read) begin
        check("mon_rd_add", 32'(ram_add), 32'(rd_m));
        rd_m = rd_m + 9'd1;
      end
      if (flush) begin
        check("mon_flush_ram_en", 32'(ram_en), 32'd0);
        sb.delete();
        wr_m = '0;
        rd_m = '0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("mon_pop_nonempty", 32'(sb.size()), 32'd1);
          end else begin
            check("mon_pop_data", 32'(out_data), 32'(sb.pop_front()));
          end
          pops++;
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic push(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = (level == '0) && !out_valid;
    end
    check(name, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          orr;
    logic          ir;
    logic          wr;
    logic          rd;
    logic [AW-1:0] add;
    logic [AW:0]   lvl;
  } vec_t;

`ifdef RAM_FIFO_BYPASS_EN
  localparam int NV = 4;
`else
  localparam int NV = 5;
`endif
  vec_t vt [NV];

  initial begin
    int start;
    int stalls;
    bit seen;
    int mc;

`ifdef RAM_FIFO_BYPASS_EN
    vt[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 10'd0};
    vt[1] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 10'd1};
    vt[2] = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b0, 9'd1, 10'd2};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd2, 10'd3};
`else
    vt[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 10'd0};
    vt[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 10'd1};
    vt[2] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b0, 9'd1, 10'd1};
    vt[3] = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b0, 9'd2, 10'd2};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd3, 10'd3};
`endif

    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, then reset asserted in the middle of a write.
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'h0777;
    @(negedge clk);
    check("midwr_ram_write", 32'(ram_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_mid_level", 32'(level), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_level", 32'(level), 32'd0);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table: three pushes with the consumer stalled.
    for (int i = 0; i < NV; i++) begin
      in_valid  = vt[i].iv;
      in_data   = vt[i].d;
      out_ready = vt[i].orr;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vt[i].ir));
      check($sformatf("tbl%0d_ram_write", i), 32'(ram_write), 32'(vt[i].wr));
      check($sformatf("tbl%0d_ram_read", i), 32'(ram_read), 32'(vt[i].rd));
      check($sformatf("tbl%0d_ram_add", i), 32'(ram_add), 32'(vt[i].add));
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(vt[i].lvl));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("tbl_head", 32'(out_data), 32'h1111);
    check("tbl_level3", 32'(level), 32'd3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty("tbl_drain", 50);
    out_ready = 1'b0;

    // Fill to DEPTH+1, hold the next push, drain in order.
    for (int i = 0; i < DEPTH + 1; i++) push(16'(i));
    @(negedge clk);
    check("full_level", 32'(level), 32'(DEPTH + 1));
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("full_hold", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty("full_drain", 2000);
    out_ready = 1'b0;

    // Wrap: 600 words through the RAM with a toggling consumer.
    start = pops;
    fork
      begin
        for (int i = 0; i < 600; i++) push(16'h1000 + 16'(i));
      end
      begin
        for (int c = 0; c < 5000 && pops < start + 600; c++) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
      end
    join
    check("wrap_pops", 32'(pops - start), 32'd600);
    wait_empty("wrap_empty", 10);

    // Fetch wins over a simultaneous push until the RAM is empty.
    for (int i = 0; i < 6; i++) push(16'h2000 + 16'(i));
    in_valid  = 1'b1;
    in_data   = 16'h5000;
    out_ready = 1'b1;
    stalls = 0;
    seen   = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      mc = int'(level) - int'(out_valid);
      check("sim_in_ready", 32'(in_ready), 32'(mc == 0));
      if (in_ready) seen = 1'b1;
      else stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sim_stalls", 32'(stalls), 32'd5);
    wait_empty("sim_drain", 50);
    out_ready = 1'b0;

    // Flush with seven words held; the next push is the new head.
    for (int i = 0; i < 7; i++) push(16'h3000 + 16'(i));
    @(negedge clk);
    check("fl_level7", 32'(level), 32'd7);
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    @(negedge clk);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_level0", 32'(level), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    push(16'hABCD);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("fl_seen", 32'(seen), 32'd1);
    check("fl_head", 32'(out_data), 32'hABCD);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty("fl_drain", 20);
    out_ready = 1'b0;

    // Push-to-out_valid latency from an empty FIFO.
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    @(negedge clk);
`ifdef RAM_FIFO_BYPASS_EN
    check("lat_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_out_valid1", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h5A5A);
    check("lat_ram_en2", 32'(ram_en), 32'd0);
`else
    check("lat_ram_write", 32'(ram_write), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_out_valid1", 32'(out_valid), 32'd0);
    check("lat_ram_read", 32'(ram_read), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_out_valid2", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h5A5A);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty("lat_drain", 10);
    out_ready = 1'b0;
    check("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
